// File: rtl/servile_wb_resp_if.sv
// Wishbone ext-bus bundle between the servile mux (master) and a responder (slave).
interface servile_wb_resp_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/servile_wb_resp.sv
// Wishbone responder: DEPTH-word byte-writable bank behind a programmable wait-state FSM.
// Define SERVILE_WB_RESP_STRICT_EN to reject accesses with address bits [29:AW+2] set.
module servile_wb_resp #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  servile_wb_resp_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [31:0]   rdt_reg;
  logic [31:0]   bank [DEPTH];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          go_ack;
  logic          wr_en;
  logic [31:0]   lane_mask;
  logic          unused_adr;

  assign idx        = wb.i_wb_adr[AW+1:2];
  assign unused_adr = ^wb.i_wb_adr;

`ifdef SERVILE_WB_RESP_STRICT_EN
  // [31:30] carry the mux select and are deliberately not checked.
  assign in_range = ~|wb.i_wb_adr[29:AW+2];
`else
  assign in_range = 1'b1;
`endif

  // True on the edge that enters ACK; write commit and read capture both key off it.
  assign go_ack = wb.i_wb_stb &&
                  (((state_reg == ST_IDLE) && (WAIT_STATES == 0)) ||
                   ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)));
  assign wr_en  = go_ack && wb.i_wb_we && in_range;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{wb.i_wb_sel[gi]}};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= 32'h0;
      end
    end else if (wr_en) begin
      bank[idx] <= (bank[idx] & ~lane_mask) | (wb.i_wb_dat & lane_mask);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      rdt_reg   <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (wb.i_wb_stb) begin
            if (WAIT_STATES == 0) begin
              state_reg <= ST_ACK;
            end else begin
              cnt_reg   <= WAIT_LOAD;
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wb.i_wb_stb) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ST_ACK;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_ACK:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase

      if (go_ack && !wb.i_wb_we) begin
        rdt_reg <= in_range ? bank[idx] : 32'h0;
      end
    end
  end

  assign wb.o_wb_ack = (state_reg == ST_ACK);
  assign wb.o_wb_rdt = rdt_reg;
endmodule

// File: tb/tb_servile_wb_resp.sv
// Bench for servile_wb_resp: two instances (2 and 0 wait states) against a word-array reference model.
module tb_servile_wb_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we  = 1'b0;
  logic        m_stb = 1'b0;
  logic        use0  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model   [2][16];
  logic [31:0] last_rd [2];

  servile_wb_resp_if wb2 ();
  servile_wb_resp_if wb0 ();

  assign wb2.i_wb_adr = m_adr;
  assign wb2.i_wb_dat = m_dat;
  assign wb2.i_wb_sel = m_sel;
  assign wb2.i_wb_we  = m_we;
  assign wb2.i_wb_stb = m_stb & ~use0;
  assign wb0.i_wb_adr = m_adr;
  assign wb0.i_wb_dat = m_dat;
  assign wb0.i_wb_sel = m_sel;
  assign wb0.i_wb_we  = m_we;
  assign wb0.i_wb_stb = m_stb & use0;

  servile_wb_resp #(.DEPTH(16), .WAIT_STATES(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .wb(wb2.slave)
  );
  servile_wb_resp #(.DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .wb(wb0.slave)
  );

  logic        ack;
  logic [31:0] rdt;
  assign ack = use0 ? wb0.o_wb_ack : wb2.o_wb_ack;
  assign rdt = use0 ? wb0.o_wb_rdt : wb2.o_wb_rdt;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
`ifdef SERVILE_WB_RESP_STRICT_EN
    return (a[29:6] == 24'h0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int exp_lat();
    return use0 ? 1 : 3;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      last_rd[k] = 32'h0;
      for (int w = 0; w < 16; w++) model[k][w] = 32'h0;
    end
  endtask

  // One full transfer: stb raised at a negedge, held until ack, bounded wait.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] r, output int lat);
    @(negedge clk);
    m_adr = a; m_dat = d; m_sel = s; m_we = w; m_stb = 1'b1;
    lat = 0;
    r = 'x;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack === 1'b1) begin
        r = rdt;
        break;
      end
    end
    m_stb = 1'b0;
    @(negedge clk);
    chk("ack_width", {31'b0, ack}, 32'h0);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic w, input string tag);
    int k;
    int lat;
    logic [31:0] r;
    k = use0 ? 1 : 0;
    xfer(a, d, s, w, r, lat);
    chk({tag, "_lat"}, lat, exp_lat());
    if (w && in_rng(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[k][a[5:2]][8*b +: 8] = d[8*b +: 8];
    end
    if (!w) last_rd[k] = in_rng(a) ? model[k][a[5:2]] : 32'h0;
    chk({tag, "_rdt"}, r, last_rd[k]);
    $display("op %s dut_ws%0d we=%0d adr=%h dat=%h sel=%b lat=%0d rdt=%h", tag,
             use0 ? 0 : 2, w, a, d, s, lat, r);
  endtask

  initial begin
    int seen;
    int t;
    int prev;
    int nack;
    int ws;
    int lat;
    logic [31:0] r;
    logic [31:0] rnd;
    logic [3:0]  widx;

    clear_model();

    // Reset held from time zero; check mid-cycle then release on a negedge.
    #22;
    chk("reset_ack", {31'b0, wb2.o_wb_ack}, 32'h0);
    chk("reset_rdt", wb2.o_wb_rdt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) op(32'hC000_0000 + 32'(4 * w), 32'h0, 4'h0, 1'b0, "rst_rd");

    op(32'hC000_0004, 32'h1234_5678, 4'b1111, 1'b1, "wr1");
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "rd1");
    op(32'hC000_0004, 32'hA5A5_A5A5, 4'b0010, 1'b1, "wr_lane");
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "rd_lane");
    op(32'hC000_0004, 32'hDEAD_BEEF, 4'b0000, 1'b1, "wr_sel0");
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "rd_sel0");

    // Abort: stb dropped while in WAIT must never produce an ack or a write.
    @(negedge clk);
    m_adr = 32'hC000_0004; m_dat = 32'hFFFF_FFFF; m_sel = 4'hF; m_we = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    m_stb = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen++;
    end
    chk("abort_noack", seen, 0);
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "rd_abort");

    op(32'hC000_0044, 32'h0, 4'b0000, 1'b0, "rd_alias");

    // Asynchronous reset asserted mid-cycle while ack is high on a read.
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "rd_pre_rst");
    @(negedge clk);
    m_adr = 32'hC000_0004; m_we = 1'b0; m_stb = 1'b1;
    t = 0;
    while (t < 40 && ack !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    m_stb = 1'b0;
    #1;
    chk("async_rst_ack", {31'b0, ack}, 32'h0);
    chk("async_rst_rdt", rdt, 32'h0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT of a write to word 2.
    op(32'hC000_0008, 32'h5555_AAAA, 4'hF, 1'b1, "wr_w2");
    @(negedge clk);
    m_adr = 32'hC000_0008; m_dat = 32'h7777_7777; m_sel = 4'hF; m_we = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m_stb = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen++;
    end
    chk("rst_wait_noack", seen, 0);
    clear_model();
    rst = 1'b0;
    op(32'hC000_0008, 32'h0, 4'b0000, 1'b0, "rd_w2");

    // Zero wait states.
    use0 = 1'b1;
    op(32'hC000_0004, 32'h1234_5678, 4'b1111, 1'b1, "ws0_wr");
    op(32'hC000_0004, 32'h0, 4'b0000, 1'b0, "ws0_rd");

    // Back-to-back: stb held high; ack period is one ACK + one IDLE + WAIT_STATES+1 edges.
    for (int k = 0; k < 2; k++) begin
      use0 = (k == 1);
      ws   = use0 ? 0 : 2;
      @(negedge clk);
      m_adr = 32'hC000_0004; m_we = 1'b0; m_stb = 1'b1;
      prev = -1;
      nack = 0;
      for (t = 1; t <= 24; t++) begin
        @(negedge clk);
        if (ack === 1'b1) begin
          if (prev >= 0) chk("b2b_gap", t - prev, ws + 2);
          prev = t;
          nack++;
        end
      end
      m_stb = 1'b0;
      chk("b2b_count", nack, (24 - (ws + 1)) / (ws + 2) + 1);
      last_rd[k] = model[k][1];
      $display("b2b dut_ws%0d acks=%0d", ws, nack);
      repeat (4) @(negedge clk);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      use0 = 1'($urandom_range(0, 1));
      rnd  = $urandom;
      widx = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        r = {rnd[31:6], widx, rnd[1:0]};
      else
        r = {rnd[31:30], 24'h0, widx, rnd[1:0]};
      op(r, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
    end

    // Final sweep of both banks.
    for (int k = 0; k < 2; k++) begin
      use0 = (k == 1);
      for (int w = 0; w < 16; w++) op(32'(4 * w), 32'h0, 4'h0, 1'b0, "sweep");
    end

    lat = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/servile_wb_resp.md
Name: servile_wb_resp

Overview:
- Wishbone responder (slave) for the servile external port: the far end of the CPU-side mux's ext bus.
- Provides a DEPTH-word, byte-writable register bank behind a programmable wait-state FSM.
- Serves as a real ext-bus target and as a timing-controllable bus model for mux/CPU bring-up.
- Address decode above the bank index is assumed done upstream by the mux.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..256; AW = $clog2(DEPTH).
- WAIT_STATES, 2, extra cycles inserted before ack; 0..15.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_wb_adr  in  32  byte address; word index = i_wb_adr[AW+1:2]; bits [1:0] ignored.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables; bit n enables byte lane [8n+7:8n].
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_stb  in  1  request strobe; master holds it high until ack.
- o_wb_rdt  out  32  read data; valid in the ack cycle of a read.
- o_wb_ack  out  1  one-cycle transfer acknowledge.

Behaviour:
- Reset, asynchronous, while i_rst=1:
  - o_wb_ack=0, o_wb_rdt=0, FSM=IDLE, wait counter=0.
  - All bank words = 32'h0.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If i_wb_stb=1 and WAIT_STATES=0: go to ACK.
  - If i_wb_stb=1 and WAIT_STATES>0: load counter with WAIT_STATES-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If i_wb_stb=0: abort. Go to IDLE; no write, no ack, o_wb_rdt unchanged.
  - Else if counter=0: go to ACK.
  - Else decrement the counter.
- ACK:
  - o_wb_ack=1 for exactly this one cycle; always go to IDLE next.
  - i_wb_stb is not sampled as a new request in the ACK cycle.
  - Back-to-back requests therefore see one IDLE cycle between acks.
- Latency: ack is high in the cycle starting WAIT_STATES+1 rising edges after the edge that first samples i_wb_stb=1 in IDLE.
- o_wb_ack is registered (driven from the state flop); there is no combinational path from stb to ack.
- Write commit:
  - Happens on the edge entering ACK, using adr/dat/sel/we sampled at that edge.
  - Master holds these stable while stb is high.
  - Only lanes with sel=1 are updated; sel=4'b0000 is still acked and changes nothing.
- Read:
  - o_wb_rdt is loaded on the edge entering ACK with bank[index].
  - It holds that value until the next read's ACK entry.
  - Writes never alter o_wb_rdt.
- Addressing: without the optional feature, bits [31:AW+2] are ignored, so the bank aliases every DEPTH*4 bytes.
- Reset mid-transaction (any state): FSM returns to IDLE at once, ack drops, the pending write is discarded.
  - After reset release the master must re-issue the request.
- i_wb_stb low in IDLE or ACK has no effect.

Optional Feature:
- Macro: SERVILE_WB_RESP_STRICT_EN.
- Defined:
  - Address bits [29:AW+2] are checked; any bit set marks the access out-of-range.
  - Bits [31:30] are ignored, since they are the mux select.
  - Out-of-range writes are acked with normal latency but leave the bank unchanged.
  - Out-of-range reads are acked with normal latency and load o_wb_rdt=32'h0.
- Undefined: no range check; full aliasing as above. Ports are identical in both builds.

Test Plan:
- Reset: assert i_rst=1 asynchronously mid-cycle → o_wb_ack=0 and o_wb_rdt=0 immediately; after release, reads of words 0..15 all return 32'h0.
- Write/read latency (DEPTH=16, WAIT_STATES=2):
  - Write 32'h12345678 to 32'hC000_0004 with sel=4'b1111 → ack high exactly 3 edges after stb is sampled, one cycle wide.
  - Read of 32'hC000_0004 → o_wb_rdt=32'h12345678 in its ack cycle.
- Byte lanes: write 32'hA5A5A5A5 to 32'hC000_0004 with sel=4'b0010 → subsequent read returns 32'h1234A578; write with sel=4'b0000 → still acked, read unchanged.
- Abort: write 32'hFFFFFFFF to word 1, raising stb for one cycle then dropping it in WAIT → no ack ever; read of word 1 returns 32'h1234A578.
- Alias/strict: read 32'hC000_0044 → macro undefined: 32'h1234A578; macro defined: 32'h0 with ack at the same latency.
- Reset mid-WAIT, plus edge cases:
  - Assert i_rst during WAIT of a write to word 2 → no ack; after release word 2 reads 32'h0.
  - Rerun the first write with WAIT_STATES=0 → ack on the first edge after stb is sampled.
  - Hold stb high back-to-back → acks separated by exactly one idle cycle.
